// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: decoder control bundle, ID/EX payload, opcodes.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned CNT_W   = 16;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd4;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rdata1;
    logic [XLEN-1:0]   rdata2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc4;
  } ex_data_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the ID operands.
module hazard_detect
  import mips_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hazard_c
);

  // A load into $zero never produces a value worth waiting for.
  assign hazard_c = ex_valid & ex_mem_read & id_valid & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch flush.
// Optional LOAD_USE_CNT_EN adds a saturating stall_cnt output.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_RegDst,
  input  logic               id_ALUSrc,
  input  logic               id_MemtoReg,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_Branch,
  input  logic [ALUOP_W-1:0] id_ALUOP,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [XLEN-1:0]    id_rdata1,
  input  logic [XLEN-1:0]    id_rdata2,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_pc4,
  input  logic               id_valid,
  input  logic               flush,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic               ex_MemtoReg,
  output logic               ex_RegWrite,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_Branch,
  output logic [ALUOP_W-1:0] ex_ALUOP,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [XLEN-1:0]    ex_rdata1,
  output logic [XLEN-1:0]    ex_rdata2,
  output logic [XLEN-1:0]    ex_imm,
  output logic [XLEN-1:0]    ex_pc4,
  output logic               ex_valid,
  output logic               stall
`ifdef LOAD_USE_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  state_e   state_q, state_d;
  ctrl_t    id_ctrl, ex_ctrl_q, ctrl_d;
  ex_data_t id_data, ex_data_q;
  logic     hazard_c;
  logic     bubble;
  logic     valid_d;

  assign id_ctrl = '{reg_dst:    id_RegDst,
                     alu_src:    id_ALUSrc,
                     mem_to_reg: id_MemtoReg,
                     reg_write:  id_RegWrite,
                     mem_read:   id_MemRead,
                     mem_write:  id_MemWrite,
                     branch:     id_Branch,
                     alu_op:     id_ALUOP};

  assign id_data = '{rs: id_rs, rt: id_rt, rd: id_rd,
                     rdata1: id_rdata1, rdata2: id_rdata2,
                     imm: id_imm, pc4: id_pc4};

  hazard_detect u_hazard (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rt       (ex_data_q.rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard_c    (hazard_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next state, stall and bubble select; flush dominates everything.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
      bubble  = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard_c) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = ST_STALL;
          end
        end
        ST_STALL: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
    ctrl_d  = (bubble || !id_valid) ? CTRL_BUBBLE : id_ctrl;
    valid_d = !bubble && id_valid;
  end

  // Pipeline register; operand fields hold across an inserted bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_q <= CTRL_BUBBLE;
      ex_data_q <= '0;
      ex_valid  <= 1'b0;
    end else begin
      ex_ctrl_q <= ctrl_d;
      ex_valid  <= valid_d;
      if (!bubble) ex_data_q <= id_data;
    end
  end

`ifdef LOAD_USE_CNT_EN
  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

  assign ex_RegDst   = ex_ctrl_q.reg_dst;
  assign ex_ALUSrc   = ex_ctrl_q.alu_src;
  assign ex_MemtoReg = ex_ctrl_q.mem_to_reg;
  assign ex_RegWrite = ex_ctrl_q.reg_write;
  assign ex_MemRead  = ex_ctrl_q.mem_read;
  assign ex_MemWrite = ex_ctrl_q.mem_write;
  assign ex_Branch   = ex_ctrl_q.branch;
  assign ex_ALUOP    = ex_ctrl_q.alu_op;
  assign ex_rs       = ex_data_q.rs;
  assign ex_rt       = ex_data_q.rt;
  assign ex_rd       = ex_data_q.rd;
  assign ex_rdata1   = ex_data_q.rdata1;
  assign ex_rdata2   = ex_data_q.rdata2;
  assign ex_imm      = ex_data_q.imm;
  assign ex_pc4      = ex_data_q.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed load-use/flush/reset cases plus random traffic.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, id_valid;
  logic [8:0]  id_c;
  logic        id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
  logic [1:0]  id_ALUOP;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic        ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
  logic [1:0]  ex_ALUOP;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic        ex_valid, stall;
  logic [15:0] stall_cnt;
  logic [8:0]  ex_c;

  assign {id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
          id_MemWrite, id_Branch, id_ALUOP} = id_c;
  assign ex_c = {ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
                 ex_MemWrite, ex_Branch, ex_ALUOP};
`ifndef LOAD_USE_CNT_EN
  assign stall_cnt = 16'h0;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_Branch(id_Branch), .id_ALUOP(id_ALUOP),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .id_valid(id_valid), .flush(flush),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_Branch(ex_Branch), .ex_ALUOP(ex_ALUOP),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_valid(ex_valid), .stall(stall)
`ifdef LOAD_USE_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference: what the EX slot should hold, whether the last cycle stalled, stall count.
  logic [8:0]  m_ctrl;
  logic        m_valid, m_stalled;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_d1, m_d2, m_imm, m_pc4;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decoder table: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOP}.
  function automatic logic [8:0] decode(input logic [5:0] op);
    case (op)
      OP_RTYPE: return 9'b1_0_0_1_0_0_0_10;
      OP_LW:    return 9'b0_1_1_1_1_0_0_00;
      OP_SW:    return 9'b0_1_0_0_0_1_0_00;
      OP_BEQ:   return 9'b0_0_0_0_0_0_1_01;
      default:  return 9'b0;
    endcase
  endfunction

  task automatic set_instr(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd);
    id_c      = decode(op);
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    id_rdata1 = $urandom;
    id_rdata2 = $urandom;
    id_imm    = $urandom;
    id_pc4    = $urandom;
    id_valid  = 1'b1;
  endtask

  // One clock: check stall before the edge, advance the model, check EX after the edge.
  task automatic step(input bit check_stall);
    logic exp_stall;
    #1;
    exp_stall = !m_stalled && !flush && m_valid && m_ctrl[4] && id_valid &&
                (m_rt != 5'd0) && (m_rt == id_rs || m_rt == id_rt);
    if (check_stall) chk("stall", 32'(stall), 32'(exp_stall));
    @(posedge clk);
    if (!rst_n) begin
      m_ctrl = '0; m_valid = 1'b0; m_stalled = 1'b0; m_cnt = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc4 = '0;
    end else begin
      if (flush || exp_stall) begin
        m_ctrl  = '0;
        m_valid = 1'b0;
      end else begin
        m_ctrl  = id_valid ? id_c : 9'b0;
        m_valid = id_valid;
        m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
        m_d1 = id_rdata1; m_d2 = id_rdata2; m_imm = id_imm; m_pc4 = id_pc4;
      end
      m_stalled = exp_stall;
      if (exp_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    #1;
    chk("ex_ctrl", 32'(ex_c), 32'(m_ctrl));
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_regs", 32'({ex_rs, ex_rt, ex_rd}), 32'({m_rs, m_rt, m_rd}));
    chk("ex_rdata1", ex_rdata1, m_d1);
    chk("ex_rdata2", ex_rdata2, m_d2);
    chk("ex_imm", ex_imm, m_imm);
    chk("ex_pc4", ex_pc4, m_pc4);
`ifdef LOAD_USE_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    @(negedge clk);
  endtask

  task automatic nop();
    set_instr(OP_RTYPE, 5'd0, 5'd0, 5'd0);
    id_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; nop();
    step(1'b1);
    rst_n = 1'b1;
  endtask

  // lw into rt=r followed by a dependent add; holds ID while stalled.
  task automatic load_use_pair(input logic [4:0] r);
    set_instr(OP_LW, 5'd1, r, 5'd0); step(1'b1);
    set_instr(OP_RTYPE, r, 5'd9, 5'd10); step(1'b1);
    step(1'b1);
    nop(); step(1'b1);
  endtask

  initial begin
    m_ctrl = '0; m_valid = 1'b0; m_stalled = 1'b0; m_cnt = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_pc4 = '0;

    // Reset held two cycles with random ID inputs.
    rst_n = 1'b0; flush = 1'(($urandom & 1));
    set_instr(6'($urandom_range(0, 63)), 5'($urandom), 5'($urandom), 5'($urandom));
    step(1'b0);
    set_instr(OP_LW, 5'($urandom), 5'($urandom), 5'($urandom));
    step(1'b1);
    chk("rst_stall", 32'(stall), 32'(0));
    rst_n = 1'b1; flush = 1'b0;

    // lw $8 then add using $8: one stall, one bubble, then the add.
    set_instr(OP_LW, 5'd1, 5'd8, 5'd0); step(1'b1);
    set_instr(OP_RTYPE, 5'd8, 5'd9, 5'd10);
    #1 chk("lu_stall_hi", 32'(stall), 32'(1));
    step(1'b1);
    chk("lu_bubble_regwrite", 32'(ex_RegWrite), 32'(0));
    chk("lu_bubble_valid", 32'(ex_valid), 32'(0));
    #1 chk("lu_stall_lo", 32'(stall), 32'(0));
    step(1'b1);
    chk("lu_add_aluop", 32'(ex_ALUOP), 32'(2'b10));
    chk("lu_add_regdst", 32'(ex_RegDst), 32'(1));

    // lw $0 then add using $0: never stalls.
    set_instr(OP_LW, 5'd1, 5'd0, 5'd0); step(1'b1);
    set_instr(OP_RTYPE, 5'd0, 5'd0, 5'd11); step(1'b1);
    chk("zero_add_valid", 32'(ex_valid), 32'(1));

    // lw $5 then sw $5 killed by a flush on the hazard cycle.
    set_instr(OP_LW, 5'd1, 5'd5, 5'd0); step(1'b1);
    set_instr(OP_SW, 5'd2, 5'd5, 5'd0); flush = 1'b1;
    #1 chk("flush_stall", 32'(stall), 32'(0));
    step(1'b1);
    flush = 1'b0;
    set_instr(OP_SW, 5'd2, 5'd5, 5'd0); step(1'b1);

    // Reset landing on the cycle after a stall.
    set_instr(OP_LW, 5'd1, 5'd7, 5'd0); step(1'b1);
    set_instr(OP_RTYPE, 5'd7, 5'd3, 5'd4); step(1'b1);
    rst_n = 1'b0; step(1'b1);
    chk("rst_mid_valid", 32'(ex_valid), 32'(0));
    rst_n = 1'b1; step(1'b1);

`ifdef LOAD_USE_CNT_EN
    // Three separate load-use pairs count three stalls; then saturation.
    do_reset();
    load_use_pair(5'd8); load_use_pair(5'd12); load_use_pair(5'd31);
    chk("cnt_three", 32'(stall_cnt), 32'(3));
    force dut.stall_cnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    m_cnt = 16'hFFFE;
    load_use_pair(5'd6); load_use_pair(5'd6);
    chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
    load_use_pair(5'd2);
    chk("cnt_sat_hold", 32'(stall_cnt), 32'hFFFF);
`endif

    // Random traffic on a small register set to provoke frequent hazards.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      rst_n = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 7) == 0);
      if (!m_stalled) begin
        case ($urandom_range(0, 3))
          0: op = OP_RTYPE;
          1: op = OP_LW;
          2: op = OP_SW;
          default: op = OP_BEQ;
        endcase
        set_instr(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
        id_valid = ($urandom_range(0, 7) != 0);
      end
      step(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have inputs id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, 1 each; main-decoder control lines.
REQ-004 SHALL have input id_ALUOP, 2, {ALUOP1,ALUOP0} from the main decoder.
REQ-005 SHALL have inputs id_rs, id_rt, id_rd, 5 each; instruction register fields.
REQ-006 SHALL have inputs id_rdata1, id_rdata2, id_imm, id_pc4, 32 each; register reads, sign-extended immediate, PC+4.
REQ-007 SHALL have input id_valid, 1; ID slot holds a real instruction.
REQ-008 SHALL have input flush, 1; branch taken, kill the instruction entering EX.
REQ-009 SHALL have outputs ex_<name> for every REQ-003..006 input, same widths; registered EX-stage copies.
REQ-010 SHALL have output ex_valid, 1; EX slot holds a real instruction.
REQ-011 SHALL have output stall, 1; freeze PC and IF/ID register this cycle.
REQ-012 SHALL have output stall_cnt, 16; load-use stall count, present only per REQ-024.

Function
REQ-013 SHALL detect a load-use hazard, combinationally: ex_valid & ex_MemRead & id_valid & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
REQ-014 SHALL run FSM RUN/STALL: RUN->STALL on hazard without flush; STALL->RUN unconditionally next cycle.
REQ-015 SHALL assert stall combinationally whenever hazard is detected in RUN and flush=0; stall=0 in STALL.
REQ-016 SHALL on a hazard cycle load a bubble: all ex_ control lines, ex_ALUOP and ex_valid = 0; data/field registers don't-care but hold.
REQ-017 SHALL in STALL load the (held) ID inputs normally, giving exactly one bubble per load-use pair.
REQ-018 SHALL otherwise load all ID inputs into ex_ registers each cycle; latency exactly 1 cycle.
REQ-019 SHALL give flush priority: flush=1 loads a bubble, forces stall=0, next state RUN, regardless of hazard or state.
REQ-020 SHALL treat id_valid=0 as bubble: ex_valid=0 and all ex_ control lines 0.
REQ-021 SHALL never stall on a destination of register 0 (lw to $zero).

Reset
REQ-022 SHALL on rst_n=0 at a clock edge: state RUN, all ex_ outputs 0, ex_valid 0, stall_cnt 0; stall evaluates 0 since ex_valid=0.
REQ-023 SHALL let reset override flush, hazard and any state, including mid-STALL.

Configuration
REQ-024 SHALL gate with macro LOAD_USE_CNT_EN: defined -> stall_cnt increments on each cycle stall=1, saturating at 16'hFFFF, cleared only by reset; undefined -> stall_cnt port and counter absent, all else identical.

Structure
REQ-025 SHALL place in shared package mips_pkg: ctrl_t packed struct of the 9 control lines (order RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOP[1:0]), CTRL_BUBBLE constant (all 0), opcode constants R-type 0, lw 35, sw 43, beq 4.
REQ-026 SHALL isolate hazard comparison (REQ-013, REQ-021) in sub-module hazard_detect; FSM, registers and counter stay in id_ex_stage.

Verification
REQ-027 Reset: rst_n=0 two cycles with random inputs -> all ex_ outputs 0, ex_valid=0, stall=0, stall_cnt=0.
REQ-028 lw rt=8 then add rs=8,rt=9 -> stall=1 for exactly one cycle, one bubble in EX (ex_RegWrite=0, ex_valid=0), then add with ex_ALUOP=2'b10, ex_RegDst=1.
REQ-029 lw rt=0 then add rs=0 -> stall never asserted, add reaches EX next cycle.
REQ-030 lw rt=5 then sw rt=5 with flush=1 on hazard cycle -> stall=0, EX bubble, state RUN, stall_cnt unchanged.
REQ-031 With LOAD_USE_CNT_EN: three separated load-use pairs -> stall_cnt=3; preload near 16'hFFFF then one more -> stays 16'hFFFF.
REQ-032 Reset asserted in STALL cycle -> next cycle RUN, ex_valid=0, stall=0.
